// File: rtl/mcoi_display_pkg.sv
// Shared types and constants for the MCOI front-panel display scanner.
// Timing defaults assume the 100 MHz clk_from_ps domain.
package mcoi_display_pkg;

  localparam int CSEL_W           = 3;
  localparam int DEF_CLK_DIV      = 5;
  localparam int DEF_BLANK_CYCLES = 20;
  localparam int DEF_RST_HOLD     = 100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RSTHOLD = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_BLANK   = 3'd4,
    ST_LATCH   = 3'd5
  } display_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mcoi_display_shifter.sv
// Serialises one display row MSB first: CLK_DIV cycles of sclk low, then
// CLK_DIV cycles high per bit; sin only moves at the start of a low phase.
module mcoi_display_shifter
  import mcoi_display_pkg::*;
#(
  parameter int ROW_BITS = 32,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                abort_i,
  input  logic [ROW_BITS-1:0] data_i,
  output logic                sclk_o,
  output logic                sin_o,
  output logic                done_o
);

  localparam int PH_W  = cnt_width(CLK_DIV - 1);
  localparam int BIT_W = cnt_width(ROW_BITS - 1);

  logic [ROW_BITS-1:0] shreg_q, shreg_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                active_q, active_d;
  logic                sclk_q, sclk_d;
  logic                sin_q, sin_d;
  logic                last_ph;

  assign last_ph = (ph_q == PH_W'(CLK_DIV - 1));
  // Combinational so the caller can leave SHIFT on the final high cycle.
  assign done_o  = active_q && sclk_q && last_ph && (bit_q == BIT_W'(ROW_BITS - 1));
  assign sclk_o  = sclk_q;
  assign sin_o   = sin_q;

  always_comb begin
    shreg_d  = shreg_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    active_d = active_q;
    sclk_d   = sclk_q;
    sin_d    = sin_q;
    if (abort_i) begin
      active_d = 1'b0;
      sclk_d   = 1'b0;
      sin_d    = 1'b0;
      ph_d     = '0;
      bit_d    = '0;
    end else if (load_i) begin
      shreg_d  = data_i;
      sin_d    = data_i[ROW_BITS-1];
      ph_d     = '0;
      bit_d    = '0;
      sclk_d   = 1'b0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (!last_ph) begin
        ph_d = ph_q + PH_W'(1);
      end else begin
        ph_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (done_o) begin
            active_d = 1'b0;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shreg_d = shreg_q << 1;
            sin_d   = shreg_d[ROW_BITS-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      ph_q     <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      sin_q    <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      active_q <= active_d;
      sclk_q   <= sclk_d;
      sin_q    <= sin_d;
    end
  end

endmodule

// File: rtl/mcoi_display_scanner.sv
// Multiplexed front-panel display scan controller: double-buffered frame,
// one row shifted per LOAD/SHIFT/BLANK/LATCH pass, repeated while enabled.
module mcoi_display_scanner
  import mcoi_display_pkg::*;
#(
  parameter int NUM_ROWS     = 8,
  parameter int ROW_BITS     = 32,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int RST_HOLD     = DEF_RST_HOLD
) (
  input  logic                         clk_from_ps,
  input  logic                         rstn,
  input  logic                         enable,
  input  logic [NUM_ROWS*ROW_BITS-1:0] frame_i,
  input  logic                         frame_valid,
  output logic                         frame_taken,
  output logic                         busy,
  output logic                         scan_done,
  output logic                         latch,
  output logic                         blank,
  output logic [CSEL_W-1:0]            csel,
  output logic                         sclk,
  output logic                         sin,
  output logic                         mreset_vadj
);

  localparam int FRAME_W = NUM_ROWS * ROW_BITS;
  localparam int ROW_W   = cnt_width(NUM_ROWS - 1);
  localparam int CNT_W   = cnt_width(max3(RST_HOLD, BLANK_CYCLES, CLK_DIV) - 1);

  display_state_t      state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [CSEL_W-1:0]   csel_q, csel_d;
  logic                latched_q, latched_d;
  logic                pending_q, pending_d;
  logic [FRAME_W-1:0]  shadow_q, shadow_d;
  logic [FRAME_W-1:0]  active_q, active_d;
  logic                frame_taken_q, frame_taken_d;
  logic                scan_done_q, scan_done_d;

  logic [ROW_BITS-1:0] rows [NUM_ROWS];
  logic                shift_load;
  logic                shift_done;

  // frame_valid has no ready: every strobe is accepted into the shadow
  // buffer in any state, and the newest strobe always wins.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    row_d         = row_q;
    csel_d        = csel_q;
    latched_d     = latched_q;
    pending_d     = pending_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    frame_taken_d = 1'b0;
    scan_done_d   = 1'b0;

    if (frame_valid) begin
      shadow_d  = frame_i;
      pending_d = 1'b1;
    end

    if (!enable) begin
      state_d   = ST_IDLE;
      row_d     = '0;
      cnt_d     = '0;
      latched_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_RSTHOLD;
          cnt_d     = '0;
          latched_d = 1'b0;
        end
        ST_RSTHOLD: begin
          if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
            state_d = ST_LOAD;
            row_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_LOAD: begin
          // Frames only swap at the top of the scan so rows never tear.
          if (row_q == '0) begin
            if (frame_valid) begin
              active_d      = frame_i;
              pending_d     = 1'b0;
              frame_taken_d = 1'b1;
            end else if (pending_q) begin
              active_d      = shadow_q;
              pending_d     = 1'b0;
              frame_taken_d = 1'b1;
            end
          end
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (shift_done) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            csel_d  = CSEL_W'(row_q);
          end
        end
        ST_BLANK: begin
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = ST_LATCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_LATCH: begin
          if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
            state_d   = ST_LOAD;
            cnt_d     = '0;
            latched_d = 1'b1;
            if (row_q == ROW_W'(NUM_ROWS - 1)) begin
              row_d       = '0;
              scan_done_d = 1'b1;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The shifter must see a freshly swapped frame in the same LOAD cycle.
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      rows[r] = active_d[r*ROW_BITS +: ROW_BITS];
    end
  end

  assign shift_load = (state_q == ST_LOAD) && enable;

  mcoi_display_shifter #(
    .ROW_BITS (ROW_BITS),
    .CLK_DIV  (CLK_DIV)
  ) u_shifter (
    .clk     (clk_from_ps),
    .rst_n   (rstn),
    .load_i  (shift_load),
    .abort_i (!enable),
    .data_i  (rows[row_q]),
    .sclk_o  (sclk),
    .sin_o   (sin),
    .done_o  (shift_done)
  );

  always_ff @(posedge clk_from_ps or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      row_q         <= '0;
      csel_q        <= '0;
      latched_q     <= 1'b0;
      pending_q     <= 1'b0;
      shadow_q      <= '0;
      active_q      <= '0;
      frame_taken_q <= 1'b0;
      scan_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      csel_q        <= csel_d;
      latched_q     <= latched_d;
      pending_q     <= pending_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      frame_taken_q <= frame_taken_d;
      scan_done_q   <= scan_done_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign mreset_vadj = (state_q != ST_IDLE) && (state_q != ST_RSTHOLD);
  assign latch       = (state_q == ST_LATCH);
  assign blank       = ((state_q == ST_LOAD) || (state_q == ST_SHIFT)) ? !latched_q : 1'b1;
  assign csel        = csel_q;
  assign frame_taken = frame_taken_q;
  assign scan_done   = scan_done_q;

endmodule

// File: tb/tb_mcoi_display_scanner.sv
// Directed bench for mcoi_display_scanner at NUM_ROWS=2, ROW_BITS=8,
// CLK_DIV=2, BLANK_CYCLES=3, RST_HOLD=4.
module tb_mcoi_display_scanner;

  localparam int NUM_ROWS     = 2;
  localparam int ROW_BITS     = 8;
  localparam int CLK_DIV      = 2;
  localparam int BLANK_CYCLES = 3;
  localparam int RST_HOLD     = 4;
  localparam int ROW_PERIOD   = 1 + 2 * CLK_DIV * ROW_BITS + BLANK_CYCLES + CLK_DIV;
  localparam int FRAME_PERIOD = NUM_ROWS * ROW_PERIOD;

  logic        clk_from_ps;
  logic        rstn;
  logic        enable;
  logic [15:0] frame_i;
  logic        frame_valid;
  logic        frame_taken, busy, scan_done, latch, blank, sclk, sin, mreset_vadj;
  logic [2:0]  csel;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor records filled by capture()
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [2:0] cs_q[$];
  int         lw_q[$];
  int         lr_q[$];
  int         sd_q[$];
  int         ft_cnt, mrl_cnt, blank_bad;
  logic       blank_post;
  bit         seen_fall;

  mcoi_display_scanner #(
    .NUM_ROWS     (NUM_ROWS),
    .ROW_BITS     (ROW_BITS),
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .RST_HOLD     (RST_HOLD)
  ) dut (
    .clk_from_ps (clk_from_ps),
    .rstn        (rstn),
    .enable      (enable),
    .frame_i     (frame_i),
    .frame_valid (frame_valid),
    .frame_taken (frame_taken),
    .busy        (busy),
    .scan_done   (scan_done),
    .latch       (latch),
    .blank       (blank),
    .csel        (csel),
    .sclk        (sclk),
    .sin         (sin),
    .mreset_vadj (mreset_vadj)
  );

  // Clock and reset
  initial clk_from_ps = 1'b0;
  always #5 clk_from_ps = ~clk_from_ps;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_from_ps);
    #1;
  endtask

  task automatic strobe(input logic [15:0] f);
    frame_i     = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic wait_latch(input logic [2:0] row, input bit to_fall, input string tag);
    int n;
    n = 0;
    while (!(latch && csel == row) && n < 300) begin tick(); n++; end
    if (to_fall) while (latch && n < 300) begin tick(); n++; end
    n_checks++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL %s: latch of row %0d not seen, waited %0d cycles, limit 300", tag, row, n);
    end
  endtask

  task automatic capture(input int ncyc);
    logic [7:0] sh;
    int         nb, lw;
    logic       psclk, platch;
    rx_q.delete(); cs_q.delete(); lw_q.delete(); lr_q.delete(); sd_q.delete();
    ft_cnt = 0; mrl_cnt = 0; blank_bad = 0; blank_post = 1'bx; seen_fall = 0;
    sh = '0; nb = 0; lw = 0; psclk = 1'b0; platch = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      if (busy && !mreset_vadj) mrl_cnt++;
      if (frame_taken) ft_cnt++;
      if (scan_done) sd_q.push_back(c);
      if (sclk && !psclk) begin
        sh = {sh[6:0], sin};
        nb++;
        if (nb == 8) begin rx_q.push_back(sh); nb = 0; end
      end
      if (latch) begin
        nb = 0;
        lw++;
        if (!platch) begin lr_q.push_back(c); cs_q.push_back(csel); end
      end else if (platch) begin
        lw_q.push_back(lw);
        lw = 0;
        if (!seen_fall) begin seen_fall = 1; blank_post = blank; end
      end
      if (!seen_fall && busy && !blank) blank_bad++;
      psclk  = sclk;
      platch = latch;
    end
  endtask

  task automatic check_rows(input string tag);
    logic [7:0] got;
    n_checks++;
    if (rx_q.size() < exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d rows, required at least %0d", tag, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_row%0d: got %h expected %h", tag, i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b0; frame_valid = 1'b0; frame_i = '0;
    repeat (3) tick();
    n_checks++; if (latch !== 1'b0)       begin n_fail++; $display("FAIL rst_latch: got %b expected 0", latch); end
    n_checks++; if (blank !== 1'b1)       begin n_fail++; $display("FAIL rst_blank: got %b expected 1", blank); end
    n_checks++; if (csel !== 3'd0)        begin n_fail++; $display("FAIL rst_csel: got %0d expected 0", csel); end
    n_checks++; if (sclk !== 1'b0)        begin n_fail++; $display("FAIL rst_sclk: got %b expected 0", sclk); end
    n_checks++; if (sin !== 1'b0)         begin n_fail++; $display("FAIL rst_sin: got %b expected 0", sin); end
    n_checks++; if (mreset_vadj !== 1'b0) begin n_fail++; $display("FAIL rst_mreset: got %b expected 0", mreset_vadj); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (frame_taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken: got %b expected 0", frame_taken); end
    n_checks++; if (scan_done !== 1'b0)   begin n_fail++; $display("FAIL rst_done: got %b expected 0", scan_done); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_scan();
    strobe({8'h3C, 8'hA5});
    tick();
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    n_checks++; if (frame_taken !== 1'b0) begin n_fail++; $display("FAIL idle_taken: got %b expected 0", frame_taken); end
    enable = 1'b1;
    capture(200);
    n_checks++; if (mrl_cnt != RST_HOLD) begin n_fail++; $display("FAIL scan_rsthold: got %0d cycles expected %0d", mrl_cnt, RST_HOLD); end
    n_checks++; if (blank_bad != 0) begin n_fail++; $display("FAIL scan_blank_early: got %0d unblanked cycles expected 0", blank_bad); end
    n_checks++; if (blank_post !== 1'b0) begin n_fail++; $display("FAIL scan_blank_after: got %b expected 0", blank_post); end
    n_checks++; if (ft_cnt != 1) begin n_fail++; $display("FAIL scan_taken: got %0d pulses expected 1", ft_cnt); end
    exp_q = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    check_rows("scan");
    n_checks++;
    if (lw_q.size() < 4 || cs_q.size() < 4 || lr_q.size() < 2) begin
      n_fail++;
      $display("FAIL scan_latch_count: got %0d latches expected at least 4", lw_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (lw_q[i] != CLK_DIV) begin n_fail++; $display("FAIL scan_latch_w%0d: got %0d expected %0d", i, lw_q[i], CLK_DIV); end
        n_checks++;
        if (cs_q[i] !== 3'(i % 2)) begin n_fail++; $display("FAIL scan_csel%0d: got %0d expected %0d", i, cs_q[i], i % 2); end
      end
      n_checks++;
      if (lr_q[1] - lr_q[0] != ROW_PERIOD) begin
        n_fail++; $display("FAIL scan_row_period: got %0d expected %0d", lr_q[1] - lr_q[0], ROW_PERIOD);
      end
    end
    n_checks++;
    if (sd_q.size() < 2) begin
      n_fail++; $display("FAIL scan_done_count: got %0d pulses expected at least 2", sd_q.size());
    end else if (sd_q[1] - sd_q[0] != FRAME_PERIOD) begin
      n_fail++; $display("FAIL scan_done_period: got %0d expected %0d", sd_q[1] - sd_q[0], FRAME_PERIOD);
    end
  endtask

  task automatic test_back_to_back();
    wait_latch(3'd0, 1'b1, "b2b_sync");
    fork
      capture(190);
      begin
        repeat (10) tick();
        frame_i = {8'h3B, 8'h96}; frame_valid = 1'b1;
        tick();
        frame_i = {8'h81, 8'hC3};
        tick();
        frame_valid = 1'b0;
      end
    join
    exp_q = '{8'h3C, 8'hC3, 8'h81, 8'hC3};
    check_rows("b2b");
    n_checks++; if (ft_cnt != 1) begin n_fail++; $display("FAIL b2b_taken: got %0d pulses expected 1", ft_cnt); end
  endtask

  task automatic test_enable_drop();
    wait_latch(3'd1, 1'b1, "drop_sync");
    repeat (5) tick();
    strobe({8'hEE, 8'h11});
    repeat (3) tick();
    enable = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL drop_busy: got %b expected 0", busy); end
    n_checks++; if (blank !== 1'b1)       begin n_fail++; $display("FAIL drop_blank: got %b expected 1", blank); end
    n_checks++; if (sclk !== 1'b0)        begin n_fail++; $display("FAIL drop_sclk: got %b expected 0", sclk); end
    n_checks++; if (latch !== 1'b0)       begin n_fail++; $display("FAIL drop_latch: got %b expected 0", latch); end
    n_checks++; if (mreset_vadj !== 1'b0) begin n_fail++; $display("FAIL drop_mreset: got %b expected 0", mreset_vadj); end
    n_checks++; if (csel !== 3'd1)        begin n_fail++; $display("FAIL drop_csel: got %0d expected 1", csel); end
    repeat (3) tick();
    enable = 1'b1;
    capture(100);
    n_checks++; if (mrl_cnt != RST_HOLD) begin n_fail++; $display("FAIL reen_rsthold: got %0d cycles expected %0d", mrl_cnt, RST_HOLD); end
    n_checks++; if (ft_cnt != 1) begin n_fail++; $display("FAIL reen_taken: got %0d pulses expected 1", ft_cnt); end
    n_checks++; if (blank_bad != 0) begin n_fail++; $display("FAIL reen_blank_early: got %0d unblanked cycles expected 0", blank_bad); end
    n_checks++;
    if (cs_q.size() < 1) begin n_fail++; $display("FAIL reen_latch: got 0 latches expected at least 1"); end
    else if (cs_q[0] !== 3'd0) begin n_fail++; $display("FAIL reen_csel: got %0d expected 0", cs_q[0]); end
    exp_q = '{8'h11, 8'hEE};
    check_rows("reen");
  endtask

  task automatic test_reset_mid_latch();
    strobe({8'h77, 8'h66});
    wait_latch(3'd1, 1'b0, "rst_sync");
    #2;
    rstn = 1'b0;
    #1;
    n_checks++; if (latch !== 1'b0)       begin n_fail++; $display("FAIL arst_latch: got %b expected 0", latch); end
    n_checks++; if (blank !== 1'b1)       begin n_fail++; $display("FAIL arst_blank: got %b expected 1", blank); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL arst_busy: got %b expected 0", busy); end
    n_checks++; if (csel !== 3'd0)        begin n_fail++; $display("FAIL arst_csel: got %0d expected 0", csel); end
    n_checks++; if (mreset_vadj !== 1'b0) begin n_fail++; $display("FAIL arst_mreset: got %b expected 0", mreset_vadj); end
    n_checks++; if (sclk !== 1'b0 || sin !== 1'b0) begin n_fail++; $display("FAIL arst_serial: got sclk %b sin %b expected 0 0", sclk, sin); end
    tick();
    rstn = 1'b1;
    capture(100);
    n_checks++; if (mrl_cnt != RST_HOLD) begin n_fail++; $display("FAIL arst_rsthold: got %0d cycles expected %0d", mrl_cnt, RST_HOLD); end
    n_checks++; if (ft_cnt != 0) begin n_fail++; $display("FAIL arst_taken: got %0d pulses expected 0", ft_cnt); end
    exp_q = '{8'h00, 8'h00};
    check_rows("arst");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_latch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
